// File: rtl/arat_if.sv
// Retire-side bundle of the architectural RAT: ROB head slots in,
// committed map / free list / recovery strobe out.
interface arat_if;
    logic [2:0]  ready_ret;
    logic [2:0]  excep_ret;
    logic [1:0]  Type_ret   [3];
    logic [2:0]  Rw_ret     [3];
    logic [4:0]  Pw_ret     [3];
    logic [4:0]  Pw_old_ret [3];

    logic [4:0]  ARAT_P_list [8];
    logic [31:0] ARAT_freelist;
    logic        flush;
    logic [1:0]  commit_cnt;
    logic [31:0] retired_total;

    modport master (
        output ready_ret, excep_ret, Type_ret, Rw_ret, Pw_ret, Pw_old_ret,
        input  ARAT_P_list, ARAT_freelist, flush, commit_cnt, retired_total
    );

    modport slave (
        input  ready_ret, excep_ret, Type_ret, Rw_ret, Pw_ret, Pw_old_ret,
        output ARAT_P_list, ARAT_freelist, flush, commit_cnt, retired_total
    );
endinterface

// File: rtl/arat.sv
// Architectural RAT: commits up to three in-order ROB head slots per cycle
// and raises a FLUSH_LEN-cycle recovery strobe when the oldest pending slot traps.
module arat #(
    parameter int FLUSH_LEN = 1
) (
    input  logic   clk,
    input  logic   rst,
    arat_if.slave  ret
);
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state_reg;
    logic [3:0]  flush_cnt_reg;
    logic        flush_reg;
    logic [31:0] retired_reg;
    logic [4:0]  p_list_reg  [8];
    logic [4:0]  p_list_next [8];
    logic [31:0] freelist_reg;
    logic [31:0] freelist_next;

    logic [2:0]  commit;
    logic        trap;
    logic        chain_open;
    logic [1:0]  commit_cnt;

    // Walk the head slots oldest-first; the first not-ready or trapping
    // slot closes the chain for everything behind it.
    always_comb begin
        commit     = 3'b000;
        trap       = 1'b0;
        chain_open = rst && (state_reg == RUN);
        for (int k = 0; k < 3; k++) begin
            if (chain_open && ret.ready_ret[k]) begin
                if (ret.excep_ret[k]) begin
                    trap       = 1'b1;
                    chain_open = 1'b0;
                end else begin
                    commit[k] = 1'b1;
                end
            end else begin
                chain_open = 1'b0;
            end
        end
    end

    assign commit_cnt = {1'b0, commit[0]} + {1'b0, commit[1]} + {1'b0, commit[2]};

    // Apply commits in slot order so a younger slot overrides an older one;
    // within a slot the allocate is written after the free so it wins.
    always_comb begin
        p_list_next   = p_list_reg;
        freelist_next = freelist_reg;
        for (int k = 0; k < 3; k++) begin
            if (commit[k] && (ret.Type_ret[k] != 2'b11) && (ret.Rw_ret[k] != 3'd0)) begin
                p_list_next[ret.Rw_ret[k]] = ret.Pw_ret[k];
                if (ret.Pw_old_ret[k] != 5'd0) begin
                    freelist_next[ret.Pw_old_ret[k]] = 1'b1;
                end
                freelist_next[ret.Pw_ret[k]] = 1'b0;
            end
        end
        p_list_next[0]   = 5'd0;
        freelist_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 4'd0;
            flush_reg     <= 1'b0;
            retired_reg   <= 32'd0;
            freelist_reg  <= 32'hffff_ff00;
            for (int i = 0; i < 8; i++) begin
                p_list_reg[i] <= 5'(i);
            end
        end else begin
            // commit is forced to zero in FLUSH, so these hold their value there
            p_list_reg   <= p_list_next;
            freelist_reg <= freelist_next;
            retired_reg  <= retired_reg + 32'(commit_cnt);
            case (state_reg)
                RUN: begin
                    if (trap) begin
                        state_reg     <= FLUSH;
                        flush_reg     <= 1'b1;
                        flush_cnt_reg <= 4'(FLUSH_LEN - 1);
                    end
                end
                FLUSH: begin
                    if (flush_cnt_reg == 4'd0) begin
                        state_reg <= RUN;
                        flush_reg <= 1'b0;
                    end else begin
                        flush_cnt_reg <= flush_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= RUN;
                    flush_reg <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_map_out
            assign ret.ARAT_P_list[gi] = p_list_reg[gi];
        end
    endgenerate

    assign ret.ARAT_freelist = freelist_reg;
    assign ret.flush         = flush_reg;
    assign ret.commit_cnt    = commit_cnt;
    assign ret.retired_total = retired_reg;
endmodule

// File: doc/arat.md
ARAT -- requirements
Module: arat

Interface
Parameters:
REQ-001 The block SHALL have parameter FLUSH_LEN, default 1: number of cycles flush is held high, legal range 1..15.
Ports:
REQ-002 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports ready_ret[2:0], input, 1 bit each: ROB head slot k is complete.
REQ-005 The block SHALL have ports excep_ret[2:0], input, 1 bit each: ROB head slot k raised an exception.
REQ-006 The block SHALL have ports Type_ret[2:0], input, 2 bits each: 2'b11 means no destination register.
REQ-007 The block SHALL have ports Rw_ret[2:0], input, 3 bits each: architectural destination register.
REQ-008 The block SHALL have ports Pw_ret[2:0], input, 5 bits each: physical register allocated to the destination.
REQ-009 The block SHALL have ports Pw_old_ret[2:0], input, 5 bits each: physical register previously mapped to Rw_ret.
REQ-010 The block SHALL have ports ARAT_P_list[7:0], output, 5 bits each: committed architectural-to-physical map, registered.
REQ-011 The block SHALL have port ARAT_freelist, output, 32 bits: committed free list, 1 = free, registered.
REQ-012 The block SHALL have port flush, output, 1 bit: precise-exception recovery strobe to SRAT, ROB and front end, registered.
REQ-013 The block SHALL have port commit_cnt, output, 2 bits: number of slots committed in the current cycle, 0..3, combinational.
REQ-014 The block SHALL have port retired_total, output, 32 bits: running count of committed instructions, registered.

Function
REQ-015 Slot k SHALL be committed when ready_ret[k]=1, excep_ret[k]=0, every slot j<k is committed, and the FSM is in RUN.
REQ-016 Slot k SHALL trap when ready_ret[k]=1, excep_ret[k]=1, every slot j<k is committed, and the FSM is in RUN; a trapping slot SHALL NOT be committed, and no slot after it SHALL be committed.
REQ-017 When a slot with Type_ret!=2'b11 and Rw_ret!=0 commits, the next-edge effect SHALL be: ARAT_P_list[Rw_ret]<=Pw_ret; ARAT_freelist[Pw_ret]<=0; ARAT_freelist[Pw_old_ret]<=1 when Pw_old_ret!=0.
REQ-018 When a slot with Type_ret=2'b11 or Rw_ret=0 commits, it SHALL leave the map and free list unchanged and SHALL be counted.
REQ-019 Committed slots SHALL be applied in order 0,1,2 within one cycle, with a later slot overriding an earlier one. Example: slot0 R1->P9, then slot1 R1->P10 with Pw_old=P9 leaves P_list[1]=10, freelist[9]=1, freelist[10]=0.
REQ-020 If the same bit is both freed and allocated in one cycle, the later slot's action SHALL prevail; if that happens within a single slot, the allocate SHALL prevail.
REQ-021 Bit 0 of ARAT_freelist SHALL never be set to 1, and ARAT_P_list[0] SHALL never change from 0.
REQ-022 commit_cnt SHALL equal the number of committed slots, and retired_total SHALL add commit_cnt on each clock edge, wrapping modulo 2^32.
REQ-023 The FSM SHALL have states RUN and FLUSH.
REQ-024 RUN SHALL move to FLUSH on a trap; the committing slots of that cycle SHALL update state on the same edge, and flush SHALL go to 1 on that edge.
REQ-025 The first flush-high cycle SHALL present ARAT_P_list and ARAT_freelist that already include every pre-trap commit.
REQ-026 In FLUSH, a down-counter SHALL hold flush=1 for exactly FLUSH_LEN cycles and then return to RUN with flush=0.
REQ-027 In FLUSH, all retire inputs SHALL be ignored: commit_cnt=0 and no change to the map or free list.
REQ-028 A trap in the first cycle back in RUN SHALL re-enter FLUSH normally.
REQ-029 ready_ret[k]=0 SHALL block slots k+1..2 even when those slots are ready; this is not an error.

Reset
REQ-030 When rst=0, the block SHALL immediately set ARAT_P_list[i]=i for i=0..7.
REQ-031 When rst=0, the block SHALL immediately set ARAT_freelist=32'hffff_ff00.
REQ-032 When rst=0, the block SHALL immediately set flush=0, retired_total=0, FSM=RUN and the flush counter to 0.
REQ-033 commit_cnt SHALL be 0 while rst=0.
REQ-034 Reset asserted during FLUSH SHALL abort the flush immediately; after release the FSM SHALL be in RUN with flush=0.

Verification
REQ-035 The bench SHALL check: after reset, all three slots ready with no exception, R1->P8/old1, R2->P9/old2, R3->P10/old3 -> next cycle P_list[1..3]=8,9,10, freelist=32'hffff_f80e, commit_cnt was 3, retired_total=3.
REQ-036 The bench SHALL check: slot0 R1->P8, slot1 excep=1, slot2 ready -> commit_cnt=1; next cycle flush=1, P_list[1]=8, freelist bit8=0 and bit1=1; with FLUSH_LEN=1, flush=0 the cycle after.
REQ-037 The bench SHALL check: ready_ret={1,0,1}, i.e. slot1 not ready -> only slot0 commits, commit_cnt=1, slot2 map unchanged.
REQ-038 The bench SHALL check: same-cycle chain slot0 R4->P12/old4, slot1 R4->P13/old12 -> P_list[4]=13, freelist[12]=1, freelist[13]=0, freelist[4]=1.
REQ-039 The bench SHALL check: FLUSH_LEN=3 with retire inputs toggling during the flush -> flush high exactly 3 cycles, no map or count change; rst pulsed in cycle 2 -> flush=0 and reset values restored immediately.
REQ-040 The bench SHALL check: slot with Type_ret=2'b11, or with Rw_ret=0 and Pw_ret=0 -> counted in commit_cnt, map and free list unchanged, freelist bit0 stays 0.
